// File: rtl/dmem_ctl_pkg.sv
// Shared width codes, FSM state type and load formatting for the data memory controller.
package dmem_ctl_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } dmem_state_e;

   // Right-align the addressed byte/half of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] width, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lo, 3'b000};
      case (width)
         MEM_BYTE: res = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         MEM_HALF: res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default:  res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for UART transmit bytes; valid-qualified push/pop, asynchronous reset.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_valid_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_valid_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             push_en, pop_en;

   always_comb begin
      full_o   = (count_q == (PW + 1)'(DEPTH));
      empty_o  = (count_q == '0);
      count_o  = count_q;
      push_en  = push_valid_i && !full_o;
      pop_en   = pop_valid_i && !empty_o;
      // Empty FIFO presents zero rather than stale storage.
      pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
      wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/dmem_ctl.sv
// Data memory controller: byte-enable RAM plus a memory-mapped UART transmit FIFO.
module dmem_ctl
   import dmem_ctl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS     = 4096,
   parameter logic [31:0] UART_ADDR       = 32'hF6FF_F070,
   parameter int unsigned UART_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic        req_is_unsigned,
   input  logic [1:0]  req_width,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [7:0]  uart_data,
   output logic        uart_valid,
   input  logic        uart_ready
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(UART_FIFO_DEPTH) + 1;

   dmem_state_e state_q, state_d;
   logic [1:0]  lo_q, lo_d;
   logic [1:0]  width_q, width_d;
   logic        uns_q, uns_d;
   logic        fault_q, fault_d;
   logic        load_q, load_d;
   logic        uart_q, uart_d;
   logic        full_q, full_d;

   logic          is_uart, misalign, out_of_range, fault, xfer;
   logic          ram_we, fifo_push, fifo_full, fifo_empty, fifo_status_full;
   logic [CW-1:0] fifo_count;
   logic [3:0]    be;
   logic [31:0]   wdata_sh;
   logic [AW-1:0] word_idx;

   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] ram_rdata_q;

   always_comb begin
      is_uart      = (req_addr == UART_ADDR);
      misalign     = (req_width == MEM_HALF && req_addr[0]) ||
                     (req_width == MEM_WORD && req_addr[1:0] != 2'b00);
      out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
      // The UART register is exempt from alignment and range checks, not from bad widths.
      fault        = (req_width == 2'b11) || (!is_uart && (misalign || out_of_range));
      req_ready    = (state_q == IDLE) && !(req_is_store && is_uart && fifo_full);
      xfer         = req_valid && req_ready;
      ram_we       = xfer && req_is_store && !is_uart && !fault;
      fifo_push    = xfer && req_is_store && is_uart && !fault;
      word_idx     = req_addr[AW+1:2];
      wdata_sh     = req_wdata << {req_addr[1:0], 3'b000};
      fifo_status_full = (fifo_count == CW'(UART_FIFO_DEPTH));
      case (req_width)
         MEM_BYTE: be = 4'b0001 << req_addr[1:0];
         MEM_HALF: be = 4'b0011 << req_addr[1:0];
         default:  be = 4'b1111;
      endcase
   end

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      width_d = width_q;
      uns_d   = uns_q;
      fault_d = fault_q;
      load_d  = load_q;
      uart_d  = uart_q;
      full_d  = full_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = RESP;
               lo_d    = req_addr[1:0];
               width_d = req_width;
               uns_d   = req_is_unsigned;
               fault_d = fault;
               load_d  = !req_is_store;
               uart_d  = is_uart;
               full_d  = fifo_status_full;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lo_q    <= '0;
         width_q <= '0;
         uns_q   <= 1'b0;
         fault_q <= 1'b0;
         load_q  <= 1'b0;
         uart_q  <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         width_q <= width_d;
         uns_q   <= uns_d;
         fault_q <= fault_d;
         load_q  <= load_d;
         uart_q  <= uart_d;
         full_q  <= full_d;
      end
   end

   // RAM contents and read register are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
      if (xfer && !req_is_store) ram_rdata_q <= ram[word_idx];
   end

   always_comb begin
      resp_valid = (state_q == RESP);
      resp_fault = resp_valid && fault_q;
      resp_rdata = '0;
      if (resp_valid && !fault_q && load_q) begin
         resp_rdata = uart_q ? {31'b0, full_q} : fmt_load(ram_rdata_q, lo_q, width_q, uns_q);
      end
   end

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (UART_FIFO_DEPTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_i        (rst),
      .push_valid_i (fifo_push),
      .push_data_i  (req_wdata[7:0]),
      .pop_valid_i  (uart_ready),
      .pop_data_o   (uart_data),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (fifo_count)
   );

   assign uart_valid = !fifo_empty;

endmodule

// File: tb/tb_dmem_ctl.sv
// Randomised bench for dmem_ctl against a byte-array/queue reference model, plus directed checks.
module tb_dmem_ctl;
   import dmem_ctl_pkg::*;

   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] UART  = 32'hF6FF_F070;
   localparam int unsigned FD    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic        req_is_unsigned = 1'b0;
   logic [1:0]  req_width = 2'b00;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [7:0]  uart_data;
   logic        uart_valid;
   logic        uart_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int uart_mode = 0;  // 0: hold ready low, 1: hold high, 2: random

   dmem_ctl #(
      .DEPTH_WORDS     (DEPTH),
      .UART_ADDR       (UART),
      .UART_FIFO_DEPTH (FD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_is_store    (req_is_store),
      .req_is_unsigned (req_is_unsigned),
      .req_width       (req_width),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_fault      (resp_fault),
      .uart_data       (uart_data),
      .uart_valid      (uart_valid),
      .uart_ready      (uart_ready)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      if (uart_mode == 2) uart_ready = 1'($urandom_range(0, 1));
      else uart_ready = (uart_mode == 1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed memory and a byte queue for the UART FIFO.
   logic [7:0]  mm [0:DEPTH*4-1];
   logic [7:0]  fq [$];
   bit          m_resp = 0, m_fault = 0;
   logic [31:0] m_rdata = '0;
   bit          mo_pop, mo_rdy, mo_xfer, mo_uart, mo_flt, mo_push;
   logic [31:0] mo_a, mo_v;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_resp = 0; m_fault = 0; m_rdata = '0;
         fq.delete();
      end else begin
         mo_a    = req_addr;
         mo_uart = (mo_a == UART);
         mo_pop  = (fq.size() > 0) && uart_ready;
         mo_rdy  = !m_resp && !(req_is_store && mo_uart && fq.size() == FD);
         mo_xfer = req_valid && mo_rdy;
         mo_push = 0;
         if (m_resp) begin
            m_resp = 0; m_fault = 0; m_rdata = '0;
         end else if (mo_xfer) begin
            mo_flt = (req_width == 2'b11);
            if (!mo_uart) begin
               if (req_width == MEM_HALF && mo_a % 2 != 0) mo_flt = 1;
               if (req_width == MEM_WORD && mo_a % 4 != 0) mo_flt = 1;
               if (mo_a / 4 >= DEPTH) mo_flt = 1;
            end
            m_resp = 1; m_fault = mo_flt; m_rdata = '0;
            if (!mo_flt && req_is_store) begin
               if (mo_uart) mo_push = 1;
               else begin
                  mm[mo_a] = req_wdata[7:0];
                  if (req_width != MEM_BYTE) mm[mo_a+1] = req_wdata[15:8];
                  if (req_width == MEM_WORD) begin
                     mm[mo_a+2] = req_wdata[23:16];
                     mm[mo_a+3] = req_wdata[31:24];
                  end
               end
            end else if (!mo_flt) begin
               if (mo_uart) m_rdata = (fq.size() == FD) ? 32'd1 : 32'd0;
               else if (req_width == MEM_BYTE) begin
                  mo_v = {24'b0, mm[mo_a]};
                  if (!req_is_unsigned && mo_v >= 128) mo_v = mo_v + 32'hFFFF_FF00;
                  m_rdata = mo_v;
               end else if (req_width == MEM_HALF) begin
                  mo_v = {16'b0, mm[mo_a+1], mm[mo_a]};
                  if (!req_is_unsigned && mo_v >= 32768) mo_v = mo_v + 32'hFFFF_0000;
                  m_rdata = mo_v;
               end else m_rdata = {mm[mo_a+3], mm[mo_a+2], mm[mo_a+1], mm[mo_a]};
            end
         end
         if (mo_pop) void'(fq.pop_front());
         if (mo_push) fq.push_back(req_wdata[7:0]);
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      chk("resp_valid", 32'(resp_valid), 32'(m_resp));
      chk("resp_fault", 32'(resp_fault), 32'(m_resp && m_fault));
      chk("resp_rdata", resp_rdata, m_resp ? m_rdata : 32'd0);
      chk("uart_valid", 32'(uart_valid), 32'(fq.size() > 0));
      chk("uart_data", 32'(uart_data), (fq.size() > 0) ? 32'(fq[0]) : 32'd0);
      if (req_valid) begin
         chk("req_ready", 32'(req_ready),
             32'(!m_resp && !(req_is_store && req_addr == UART && fq.size() == FD)));
      end
   end

   task automatic xact(input bit st, input bit uns, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output bit f);
      bit ok;
      ok = 0; rd = '0; f = 0;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_is_unsigned = uns;
      req_width = w; req_addr = a; req_wdata = d;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (req_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 32'(ok), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      #3;
      rd = resp_rdata; f = resp_fault;
      req_valid = 1'b0;
   endtask

   logic [31:0] rd;
   bit          f;
   logic [1:0]  rw;
   logic [31:0] ra;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_uart_valid", 32'(uart_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      for (int i = 0; i < 256; i++) xact(1, 0, MEM_WORD, 32'(i * 4), {16'(i), ~16'(i)}, rd, f);

      xact(1, 0, MEM_WORD, 32'h100, 32'hDEAD_BEEF, rd, f);
      xact(0, 0, MEM_BYTE, 32'h103, 32'h0, rd, f);
      chk("lb_signed_103", rd, 32'hFFFF_FFDE);
      xact(0, 1, MEM_BYTE, 32'h103, 32'h0, rd, f);
      chk("lbu_103", rd, 32'h0000_00DE);

      xact(1, 0, MEM_WORD, 32'h200, 32'h1234_5678, rd, f);
      xact(1, 0, MEM_HALF, 32'h202, 32'h0000_8001, rd, f);
      xact(0, 0, MEM_WORD, 32'h200, 32'h0, rd, f);
      chk("lw_200", rd, 32'h8001_5678);
      xact(0, 0, MEM_HALF, 32'h202, 32'h0, rd, f);
      chk("lh_202", rd, 32'hFFFF_8001);

      xact(0, 0, MEM_WORD, 32'h102, 32'h0, rd, f);
      chk("misalign_fault", 32'(f), 32'd1);
      chk("misalign_rdata", rd, 32'd0);
      xact(1, 0, MEM_WORD, DEPTH * 4, 32'hFFFF_FFFF, rd, f);
      chk("oor_fault", 32'(f), 32'd1);
      xact(0, 0, MEM_WORD, 32'h0, 32'h0, rd, f);
      chk("oor_ram_unchanged", rd, 32'h0000_FFFF);

      uart_mode = 0;
      for (int k = 0; k < 8; k++) xact(1, 0, MEM_BYTE, UART, 32'(8'hA0 + k), rd, f);
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_width = MEM_BYTE;
      req_addr = UART; req_wdata = 32'hA8;
      #1;
      chk("uart_full_ready", 32'(req_ready), 32'd0);
      chk("uart_head", 32'(uart_data), 32'hA0);
      req_valid = 1'b0;
      xact(0, 0, MEM_WORD, UART, 32'h0, rd, f);
      chk("uart_status_full", rd, 32'd1);
      uart_mode = 1;
      xact(1, 0, MEM_BYTE, UART, 32'hA8, rd, f);
      chk("uart_9th_fault", 32'(f), 32'd0);
      repeat (15) @(negedge clk);
      #1;
      chk("uart_drained", 32'(uart_valid), 32'd0);

      uart_mode = 2;
      repeat (400) begin
         rw = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0: begin
               ra = $urandom_range(DEPTH * 4, 32'hFFFF_FFFF);
               if (ra == UART) ra = ra + 4;
            end
            1, 2: ra = UART;
            default: begin
               ra = $urandom_range(0, 1023);
               if ($urandom_range(0, 9) < 7) begin
                  if (rw == MEM_HALF) ra = ra & ~32'd1;
                  if (rw == MEM_WORD) ra = ra & ~32'd3;
               end
            end
         endcase
         xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rw, ra, $urandom, rd, f);
      end

      uart_mode = 1;
      repeat (20) @(negedge clk);
      uart_mode = 0;
      for (int k = 0; k < 3; k++) xact(1, 0, MEM_BYTE, UART, 32'(8'h50 + k), rd, f);
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b0; req_width = MEM_WORD; req_addr = 32'h100;
      #1;
      chk("pre_reset_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset_uart_valid", 32'(uart_valid), 32'd0);
      chk("post_reset_ready", 32'(req_ready), 32'd1);
      chk("post_reset_resp_valid", 32'(resp_valid), 32'd0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
